// File: rtl/alu_pkg.sv
// Opcode constants and the ALU/parity reference functions for the ALU/parity datapath.
// The source side and the checker both import this package.
package alu_pkg;

  localparam logic [2:0] OP_ADD  = 3'd0;
  localparam logic [2:0] OP_SUB  = 3'd1;
  localparam logic [2:0] OP_XOR  = 3'd2;
  localparam logic [2:0] OP_OR   = 3'd3;
  localparam logic [2:0] OP_AND  = 3'd4;
  localparam logic [2:0] OP_NOR  = 3'd5;
  localparam logic [2:0] OP_NAND = 3'd6;
  localparam logic [2:0] OP_XNOR = 3'd7;

  localparam int FUNC_W = 8;

  typedef logic [2:0] opcode_t;
  typedef logic [3:0] nibble_t;

  // 4-bit ALU. Every opcode is defined, and all arithmetic wraps modulo 16.
  function automatic nibble_t alu_eval(input opcode_t op, input nibble_t a, input nibble_t b);
    nibble_t r;
    case (op)
      OP_ADD:  r = a + b;
      OP_SUB:  r = a - b;
      OP_XOR:  r = a ^ b;
      OP_OR:   r = a | b;
      OP_AND:  r = a & b;
      OP_NOR:  r = ~(a | b);
      OP_NAND: r = ~(a & b);
      default: r = (a & b) | (~a & ~b);
    endcase
    return r;
  endfunction

  // Even parity over the four result bits (XOR reduction).
  function automatic logic parity4(input nibble_t x);
    return ^x;
  endfunction

endpackage

// File: rtl/opcode_decoder.sv
// Turns a 3-bit opcode back into the 8-bit one-hot func. This undoes the encoder on the source side.
module opcode_decoder
  import alu_pkg::*;
(
  input  logic [2:0]        opcode_i,
  output logic [FUNC_W-1:0] func_o
);

  // Drive bit i high when the opcode equals i.
  always_comb begin
    func_o = '0;
    for (int i = 0; i < FUNC_W; i++) begin
      func_o[i] = (opcode_i == 3'(i));
    end
  end

endmodule

// File: rtl/alu_result_checker.sv
// Receiving end of the ALU/parity datapath. Stage S1 decodes the opcode, S2 recomputes the
// result and its parity, and S3 compares the parity and drives the outputs. One global stall
// controls the pipeline, and the block keeps a saturating count of parity errors.
module alu_result_checker
  import alu_pkg::*;
#(
  parameter int ERR_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_opcode,
  input  logic [3:0]       in_a,
  input  logic [3:0]       in_b,
  input  logic             in_parity,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [7:0]       out_func,
  output logic [3:0]       out_result,
  output logic             out_parity_ok,
  output logic [ERR_W-1:0] err_count,
  output logic             err_sticky,
  input  logic             clear
);

  // Handshake: a transfer happens on a rising edge where valid && ready. Ready does not depend
  // on valid. When the output is held (out_valid && !out_ready), every stage freezes, so
  // in_ready falls, and out_* plus out_valid stay stable until the consumer takes the output.
  logic adv;
  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  logic [FUNC_W-1:0] dec_func;

  opcode_decoder u_opcode_decoder (
    .opcode_i (in_opcode),
    .func_o   (dec_func)
  );

  // Stage registers
  logic              s1_valid_q, s2_valid_q, s3_valid_q;
  opcode_t           s1_op_q;
  nibble_t           s1_a_q, s1_b_q;
  logic              s1_par_q, s2_par_q, s2_exp_par_q;
  logic [FUNC_W-1:0] s1_func_q, s2_func_q, s3_func_q;
  nibble_t           s2_result_q, s3_result_q;
  logic              s3_ok_q;

  // Next-state values for S2 and S3
  nibble_t           s2_result_d;
  logic              s3_ok_d;
  logic              err_event;

  // Recompute the result and check the parity. An error counts only when a valid transaction
  // actually moves into S3, so a stalled transaction is never counted twice.
  always_comb begin
    s2_result_d = alu_eval(s1_op_q, s1_a_q, s1_b_q);
    s3_ok_d     = (s2_par_q == s2_exp_par_q);
    err_event   = adv && s2_valid_q && !s3_ok_d;
  end

  // Pipeline advance. Bubbles move through the stages like transactions and are not collapsed.
  // Data registers load on every advance, whether the stage holds a transaction or a bubble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q   <= 1'b0;
      s1_op_q      <= '0;
      s1_a_q       <= '0;
      s1_b_q       <= '0;
      s1_par_q     <= 1'b0;
      s1_func_q    <= '0;
      s2_valid_q   <= 1'b0;
      s2_func_q    <= '0;
      s2_result_q  <= '0;
      s2_par_q     <= 1'b0;
      s2_exp_par_q <= 1'b0;
      s3_valid_q   <= 1'b0;
      s3_func_q    <= '0;
      s3_result_q  <= '0;
      s3_ok_q      <= 1'b0;
    end else if (adv) begin
      s1_valid_q   <= in_valid;
      s1_op_q      <= in_opcode;
      s1_a_q       <= in_a;
      s1_b_q       <= in_b;
      s1_par_q     <= in_parity;
      s1_func_q    <= dec_func;
      s2_valid_q   <= s1_valid_q;
      s2_func_q    <= s1_func_q;
      s2_result_q  <= s2_result_d;
      s2_par_q     <= s1_par_q;
      s2_exp_par_q <= parity4(s2_result_d);
      s3_valid_q   <= s2_valid_q;
      s3_func_q    <= s2_func_q;
      s3_result_q  <= s2_result_q;
      s3_ok_q      <= s3_ok_d;
    end
  end

  assign out_valid     = s3_valid_q;
  assign out_func      = s3_func_q;
  assign out_result    = s3_result_q;
  assign out_parity_ok = s3_ok_q;

  // Error bookkeeping
  logic [ERR_W-1:0] err_count_q, err_count_d;
  logic             err_sticky_q, err_sticky_d;

  // The count saturates at all-ones. If clear and an error event arrive together, clear wins.
  always_comb begin
    err_count_d  = err_count_q;
    err_sticky_d = err_sticky_q;
    if (clear) begin
      err_count_d  = '0;
      err_sticky_d = 1'b0;
    end else if (err_event) begin
      err_sticky_d = 1'b1;
      if (!(&err_count_q)) begin
        err_count_d = err_count_q + ERR_W'(1);
      end
    end
  end

  // Error counter and sticky flag registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_count_q  <= '0;
      err_sticky_q <= 1'b0;
    end else begin
      err_count_q  <= err_count_d;
      err_sticky_q <= err_sticky_d;
    end
  end

  assign err_count  = err_count_q;
  assign err_sticky = err_sticky_q;

endmodule

// File: tb/tb_alu_result_checker.sv
// Directed bench for alu_result_checker. The counter is 2 bits wide so saturation is reachable.
module tb_alu_result_checker;

  localparam int ERR_W = 2;

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       in_opcode;
  logic [3:0]       in_a;
  logic [3:0]       in_b;
  logic             in_parity;
  logic             out_valid;
  logic             out_ready;
  logic [7:0]       out_func;
  logic [3:0]       out_result;
  logic             out_parity_ok;
  logic [ERR_W-1:0] err_count;
  logic             err_sticky;
  logic             clear;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int deliv_total = 0;

  // Each entry is {func, result, parity_ok}.
  logic [12:0] exp_q[$];
  int          deliv_cyc_q[$];

  alu_result_checker #(.ERR_W(ERR_W)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_opcode     (in_opcode),
    .in_a          (in_a),
    .in_b          (in_b),
    .in_parity     (in_parity),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_func      (out_func),
    .out_result    (out_result),
    .out_parity_ok (out_parity_ok),
    .err_count     (err_count),
    .err_sticky    (err_sticky),
    .clear         (clear)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc = cyc + 1;

  // ---------------- check helper ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---------------- scoreboard ----------------
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      deliv_total++;
      deliv_cyc_q.push_back(cyc);
      if (exp_q.size() == 0) begin
        check("unexpected_output", {19'd0, out_func, out_result, out_parity_ok}, 32'hFFFF_FFFF);
      end else begin
        check("out_txn", {19'd0, out_func, out_result, out_parity_ok}, {19'd0, exp_q.pop_front()});
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one transaction and hold it until it is accepted. The expected result is computed
  // by hand for each vector, and the bench derives parity_ok from it.
  task automatic send(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b,
                      input logic par, input logic [3:0] exp_res);
    int n;
    logic [7:0] f;
    in_valid  = 1'b1;
    in_opcode = op;
    in_a      = a;
    in_b      = b;
    in_parity = par;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("send_accepted", {31'd0, in_ready}, 32'd1);
    f = 8'b1 << op;
    exp_q.push_back({f, exp_res, (par == ^exp_res)});
    tick();
  endtask

  task automatic idle();
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("drain_empty", exp_q.size(), 0);
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int lat;
    int hi_cnt;
    int base;
    rst_n = 1'b0; in_valid = 1'b0; in_opcode = '0; in_a = '0; in_b = '0;
    in_parity = 1'b0; out_ready = 1'b1; clear = 1'b0;

    // Reset values
    repeat (2) @(negedge clk);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out_func", {24'd0, out_func}, 32'd0);
    check("rst_out_result", {28'd0, out_result}, 32'd0);
    check("rst_parity_ok", {31'd0, out_parity_ok}, 32'd0);
    check("rst_err_count", {30'd0, err_count}, 32'd0);
    check("rst_err_sticky", {31'd0, err_sticky}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    tick();

    // Pass case with latency: ADD 5+A = F, parity 0
    send(3'd0, 4'h5, 4'hA, 1'b0, 4'hF);
    idle();
    lat = 0;
    while (lat < 20) begin
      @(negedge clk);
      lat++;
      if (out_valid) break;
    end
    check("pass_latency", lat, 3);
    check("pass_func", {24'd0, out_func}, 32'h01);
    check("pass_result", {28'd0, out_result}, 32'hF);
    check("pass_ok", {31'd0, out_parity_ok}, 32'd1);
    drain();
    check("pass_err_count", {30'd0, err_count}, 32'd0);
    tick();

    // Single error: SUB 1-1 = 0, parity sent 1
    send(3'd1, 4'h1, 4'h1, 1'b1, 4'h0);
    idle();
    drain();
    check("single_err_count", {30'd0, err_count}, 32'd1);
    check("single_err_sticky", {31'd0, err_sticky}, 32'd1);
    tick();
    pulse_clear();
    @(negedge clk);
    check("clear_count", {30'd0, err_count}, 32'd0);
    check("clear_sticky", {31'd0, err_sticky}, 32'd0);
    tick();

    // Full sweep, back-to-back, a=1 b=1, correct parity
    deliv_cyc_q.delete();
    send(3'd0, 4'h1, 4'h1, 1'b1, 4'b0010);
    send(3'd1, 4'h1, 4'h1, 1'b0, 4'b0000);
    send(3'd2, 4'h1, 4'h1, 1'b0, 4'b0000);
    send(3'd3, 4'h1, 4'h1, 1'b1, 4'b0001);
    send(3'd4, 4'h1, 4'h1, 1'b1, 4'b0001);
    send(3'd5, 4'h1, 4'h1, 1'b1, 4'b1110);
    send(3'd6, 4'h1, 4'h1, 1'b1, 4'b1110);
    send(3'd7, 4'h1, 4'h1, 1'b0, 4'b1111);
    idle();
    drain();
    check("sweep_count", deliv_cyc_q.size(), 8);
    for (int i = 1; i < 8 && i < deliv_cyc_q.size(); i++) begin
      check("sweep_consecutive", deliv_cyc_q[i] - deliv_cyc_q[i-1], 1);
    end
    check("sweep_err_count", {30'd0, err_count}, 32'd0);
    tick();

    // Backpressure: three transactions in flight, consumer stalled for 5 cycles
    base = deliv_total;
    out_ready = 1'b0;
    send(3'd4, 4'hC, 4'hA, 1'b0, 4'h8);  // bad parity
    send(3'd3, 4'hC, 4'h3, 1'b0, 4'hF);
    send(3'd5, 4'h2, 4'h4, 1'b0, 4'h9);
    idle();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_in_ready", {31'd0, in_ready}, 32'd0);
      check("bp_out_valid", {31'd0, out_valid}, 32'd1);
      check("bp_hold", {19'd0, out_func, out_result, out_parity_ok}, {19'd0, 8'h10, 4'h8, 1'b0});
      check("bp_err_count", {30'd0, err_count}, 32'd1);
    end
    tick();
    out_ready = 1'b1;
    drain();
    check("bp_delivered", deliv_total - base, 3);
    check("bp_err_once", {30'd0, err_count}, 32'd1);
    tick();
    pulse_clear();

    // Saturation: five bad ADD 1+2 = 3 (parity 0, sent 1)
    for (int i = 0; i < 5; i++) send(3'd0, 4'h1, 4'h2, 1'b1, 4'h3);
    idle();
    drain();
    check("sat_count", {30'd0, err_count}, 32'd3);
    check("sat_sticky", {31'd0, err_sticky}, 32'd1);
    tick();
    // Sixth error reaches S3 on the same edge that samples clear
    send(3'd0, 4'h1, 4'h2, 1'b1, 4'h3);
    idle();
    tick();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    check("clr_evt_out_valid", {31'd0, out_valid}, 32'd1);
    check("clr_evt_count", {30'd0, err_count}, 32'd0);
    check("clr_evt_sticky", {31'd0, err_sticky}, 32'd0);
    drain();
    check("clr_evt_count_after", {30'd0, err_count}, 32'd0);
    tick();

    // Reset mid-operation: bad transactions in flight, the first already in S3
    send(3'd0, 4'h1, 4'h2, 1'b1, 4'h3);
    send(3'd0, 4'h1, 4'h2, 1'b1, 4'h3);
    send(3'd0, 4'h1, 4'h2, 1'b1, 4'h3);
    idle();
    check("pre_rst_out_valid", {31'd0, out_valid}, 32'd1);
    check("pre_rst_err_count", {30'd0, err_count}, 32'd1);
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    check("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("mid_rst_err_count", {30'd0, err_count}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    hi_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (out_valid) hi_cnt++;
    end
    check("post_rst_no_output", hi_cnt, 0);
    check("post_rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("post_rst_err_count", {30'd0, err_count}, 32'd0);
    check("total_delivered", deliv_total, 19);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_result_checker.md
Name: alu_result_checker

Overview:
- Receiving end of the ALU/parity datapath. Accepts a transaction (3-bit opcode, operands a/b, transmitted parity bit) over a valid/ready handshake.
- Decodes the opcode back to the 8-bit one-hot func and recomputes the 4-bit result and its parity.
- Flags parity mismatches and keeps a saturating error count.
- 3-stage registered pipeline with global backpressure; sits between the ALU/parity source and the downstream logger or consumer.

Parameters:
ERR_W, 8, width of the saturating error counter

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  source has a transaction
in_ready  output  1  checker accepts the transaction this cycle
in_opcode  input  3  ALU opcode (0 to 7)
in_a  input  4  operand a
in_b  input  4  operand b
in_parity  input  1  parity bit sent by the source (XOR of the 4 result bits)
out_valid  output  1  checked transaction available
out_ready  input  1  consumer accepts the output
out_func  output  8  one-hot func, equal to 1<<opcode
out_result  output  4  recomputed ALU result
out_parity_ok  output  1  1 = in_parity matched the recomputed parity
err_count  output  ERR_W  number of mismatches, saturating
err_sticky  output  1  set on the first mismatch, held until clear
clear  input  1  synchronous clear of err_count and err_sticky

Behaviour:
- Reset (asynchronous, rst_n=0):
  - All stage valid bits = 0.
  - out_valid=0, out_func=0, out_result=0, out_parity_ok=0, err_count=0, err_sticky=0.
  - in_ready=1 from the first cycle after release.
  - Reset mid-operation discards all in-flight transactions; none are reported.
- Stall rule (global): adv = !out_valid || out_ready.
  - in_ready = adv.
  - When adv=1, every stage shifts by one.
  - When adv=0, all stage registers hold.
  - Input handshake: in_valid && in_ready.
- S1 (decode): captures opcode, a, b, in_parity and func=1<<opcode. s1_valid = input handshake.
- S2 (compute): result computed modulo 16, expected parity = XOR of the 4 result bits. Opcode mapping:
  - 000: a+b
  - 001: a-b
  - 010: a^b
  - 011: a|b
  - 100: a&b
  - 101: ~(a|b)
  - 110: ~(a&b)
  - 111: xnor, i.e. (a&b)|(~a&~b)
- S3 (check/output):
  - Registers func, result, and parity_ok = (in_parity == expected).
  - out_valid = s3_valid.
- Latency: 3 cycles from input handshake to out_valid with out_ready held at 1.
- Throughput: 1 transaction per cycle. Bubbles propagate and are not collapsed.
- Output hold: while out_valid=1 and out_ready=0, all outputs stay stable.
- Error counting:
  - Event = a transaction enters S3 with parity_ok=0. Counted once per transaction, at S3 capture, never again while stalled.
  - err_count += 1 on each event, saturating at 2^ERR_W - 1.
  - err_sticky is set on any event.
- clear: err_count and err_sticky go to 0 on the next edge.
  - If clear and an error event occur in the same cycle, clear wins: count=0, sticky=0.
  - clear does not affect the pipeline.
- No illegal opcode exists, because all 8 codes are defined.

Decomposition:
- Package alu_pkg:
  - Opcode localparams OP_ADD=3'd0 through OP_XNOR=3'd7.
  - Function alu_eval(op, a, b) returning [3:0].
  - Function parity4(x).
  - Shared with the source side.
- Sub-module opcode_decoder: combinational, 3-bit opcode to 8-bit one-hot. It is the inverse of the func encoder and is instantiated in S1.

Test Plan:
- Pass case: after reset, send opcode=000, a=0101, b=1010, parity=0 with out_ready=1 -> out_valid 3 cycles later, out_func=00000001, out_result=1111, out_parity_ok=1, err_count=0.
- Single error: opcode=001, a=0001, b=0001, parity=1 -> out_result=0000, out_parity_ok=0, err_count=1, err_sticky=1.
- Full sweep: all 8 opcodes with a=0001, b=0001 and correct parity, back-to-back -> results 0010, 0000, 0000, 0001, 0001, 1110, 1110, 1111, in order on consecutive cycles. out_func walks 00000001 up to 10000000; no errors.
- Backpressure: 3 transactions in flight, out_ready=0 for 5 cycles -> in_ready=0, outputs stable. Then release -> all 3 delivered in order, none lost or duplicated; any error is counted exactly once.
- Saturation and clear (ERR_W=2): 5 bad-parity transactions -> err_count stays at 3. Then clear asserted in the same cycle as a 6th error -> err_count=0, err_sticky=0.
- Reset mid-operation: rst_n pulled low with 2 transactions in flight -> out_valid=0 and err_count=0 immediately, no output after release, in_ready=1.
